universal_register: RTL and testbench

Parametrised successor to the team's 8-bit load/hold register. Holds a WIDTH-bit value and executes one of eight operations per accepted command: hold, load, multi-bit shift, multi-bit rotate, increment and decrement. Shifts and rotates run one bit per cycle under a small FSM with a valid/ready/done handshake. Carry and zero flags are provided for downstream datapath control.

---
 rtl/universal_register_if.sv | 31 +++
 rtl/universal_register.sv | 175 +++++++++++++++++
 tb/tb_universal_register.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/universal_register_if.sv
// universal_register_if: command/status bundle for universal_register.
//   master drives : op_valid, op, data_in, shamt, serial_in
//   master samples: op_ready, data_out, carry, zero, busy, done
// WIDTH  - data width in bits
// CNT_W  - shift-amount width
interface universal_register_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [CNT_W-1:0] shamt;
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             carry;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output op_valid, op, data_in, shamt, serial_in,
        input  op_ready, data_out, carry, zero, busy, done
    );

    modport slave (
        input  op_valid, op, data_in, shamt, serial_in,
        output op_ready, data_out, carry, zero, busy, done
    );
endinterface

// File: rtl/universal_register.sv
// universal_register: WIDTH-bit register with hold/load/shift/rotate/inc/dec.
// Shifts and rotates advance one bit per clock. The first step happens on the
// accept edge and the remaining steps are performed in RUN.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - universal_register_if.slave (command handshake, data and flags)
// Parameters: WIDTH (>=2), CNT_W (shamt width), SAT (1 = saturating INC/DEC)
module universal_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1,
    parameter bit SAT   = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    universal_register_if.slave bus
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_INC  = 3'b110;
    localparam logic [2:0] OP_DEC  = 3'b111;

    localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic             carry_r, carry_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       op_r, op_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [WIDTH:0]   step_s;
    logic [WIDTH:0]   run_step_s;

    // One 1-bit shift/rotate step; result is {carry, data}.
    function automatic logic [WIDTH:0] step_f(input logic [2:0] sop,
                                              input logic [WIDTH-1:0] d,
                                              input logic sin);
        logic [WIDTH:0] r;
        case (sop)
            OP_SHL:  r = {d[WIDTH-1], d[WIDTH-2:0], sin};
            OP_SHR:  r = {d[0], sin, d[WIDTH-1:1]};
            OP_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            OP_ROR:  r = {d[0], d[0], d[WIDTH-1:1]};
            default: r = {1'b0, d};
        endcase
        return r;
    endfunction

    assign step_s     = step_f(bus.op, data_r, bus.serial_in);
    assign run_step_s = step_f(op_r, data_r, bus.serial_in);

    // Next-state, datapath and flag logic.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        carry_s = carry_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.op_valid) begin
                    done_s = 1'b1;
                    case (bus.op)
                        OP_HOLD: begin
                            data_s = data_r;
                        end
                        OP_LOAD: begin
                            data_s  = bus.data_in;
                            carry_s = 1'b0;
                        end
                        OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                            // shamt==0 is a no-op that still completes
                            if (bus.shamt != C_ZERO) begin
                                {carry_s, data_s} = step_s;
                                if (bus.shamt != C_ONE) begin
                                    state_s = RUN;
                                    cnt_s   = bus.shamt - C_ONE;
                                    op_s    = bus.op;
                                    done_s  = 1'b0;
                                end else begin
                                    cnt_s = C_ZERO;
                                end
                            end else begin
                                data_s = data_r;
                            end
                        end
                        OP_INC: begin
                            if (data_r == W_ONES) begin
                                carry_s = 1'b1;
                                data_s  = SAT ? W_ONES : W_ZERO;
                            end else begin
                                carry_s = 1'b0;
                                data_s  = data_r + W_ONE;
                            end
                        end
                        OP_DEC: begin
                            if (data_r == W_ZERO) begin
                                carry_s = 1'b1;
                                data_s  = SAT ? W_ZERO : W_ONES;
                            end else begin
                                carry_s = 1'b0;
                                data_s  = data_r - W_ONE;
                            end
                        end
                        default: begin
                            data_s = data_r;
                        end
                    endcase
                end else begin
                    data_s = data_r;
                end
            end
            RUN: begin
                {carry_s, data_s} = run_step_s;
                cnt_s = cnt_r - C_ONE;
                // counter at one means this edge performs the final step
                if (cnt_r == C_ONE) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            data_r  <= W_ZERO;
            carry_r <= 1'b0;
            cnt_r   <= C_ZERO;
            op_r    <= OP_HOLD;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            carry_r <= carry_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bus.op_ready = (state_r == IDLE) && !reset;
    assign bus.data_out = data_r;
    assign bus.carry    = carry_r;
    assign bus.zero     = (data_r == W_ZERO);
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_universal_register.sv
// tb_universal_register: drives three universal_register instances
// (8-bit wrapping, 8-bit saturating, 16-bit wrapping) with the same command
// stream and compares each against an arithmetic reference model.
module tb_universal_register;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_i;
    logic [15:0] din_i;
    logic [4:0]  sh_i;
    logic        sin_i;

    int errors;
    int checks;

    universal_register_if #(.WIDTH(8))  b0 ();
    universal_register_if #(.WIDTH(8))  b1 ();
    universal_register_if #(.WIDTH(16)) b2 ();

    universal_register #(.WIDTH(8),  .SAT(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    universal_register #(.WIDTH(8),  .SAT(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    universal_register #(.WIDTH(16), .SAT(1'b0)) u2 (.clk(clk), .reset(reset), .bus(b2));

    assign b0.op_valid = op_valid;  assign b1.op_valid = op_valid;  assign b2.op_valid = op_valid;
    assign b0.op = op_i;            assign b1.op = op_i;            assign b2.op = op_i;
    assign b0.data_in = din_i[7:0]; assign b1.data_in = din_i[7:0]; assign b2.data_in = din_i;
    assign b0.shamt = sh_i[3:0];    assign b1.shamt = sh_i[3:0];    assign b2.shamt = sh_i;
    assign b0.serial_in = sin_i;    assign b1.serial_in = sin_i;    assign b2.serial_in = sin_i;

    logic [31:0] od [3];
    logic        oc [3];
    logic        oz [3];
    logic        ob [3];
    logic        odn [3];
    logic        ordy [3];

    assign od[0] = {24'd0, b0.data_out}; assign od[1] = {24'd0, b1.data_out}; assign od[2] = {16'd0, b2.data_out};
    assign oc[0] = b0.carry;    assign oc[1] = b1.carry;    assign oc[2] = b2.carry;
    assign oz[0] = b0.zero;     assign oz[1] = b1.zero;     assign oz[2] = b2.zero;
    assign ob[0] = b0.busy;     assign ob[1] = b1.busy;     assign ob[2] = b2.busy;
    assign odn[0] = b0.done;    assign odn[1] = b1.done;    assign odn[2] = b2.done;
    assign ordy[0] = b0.op_ready; assign ordy[1] = b1.op_ready; assign ordy[2] = b2.op_ready;

    // reference state per instance
    int          mw [3] = '{8, 8, 16};
    bit          msat [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] md [3];
    logic        mc [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of a whole command computed in one go: {carry, data}.
    function automatic logic [32:0] ref_op(input int w, input bit sat, input logic [2:0] o,
                                           input logic [31:0] d, input logic [31:0] din,
                                           input int n, input logic s, input logic c);
        logic [31:0] mask;
        logic [31:0] res;
        logic        cy;
        int          r;
        mask = (32'd1 << w) - 32'd1;
        res  = d;
        cy   = c;
        case (o)
            3'd1: begin res = din & mask; cy = 1'b0; end
            3'd2: if (n > 0) begin
                if (n < w) begin
                    res = ((d << n) | (s ? ((32'd1 << n) - 32'd1) : 32'd0)) & mask;
                    cy  = d[w-n];
                end else begin
                    res = s ? mask : 32'd0;
                    cy  = (n == w) ? d[0] : s;
                end
            end
            3'd3: if (n > 0) begin
                if (n < w) begin
                    res = (d >> n) | (s ? (mask & ~(mask >> n)) : 32'd0);
                    cy  = d[n-1];
                end else begin
                    res = s ? mask : 32'd0;
                    cy  = (n == w) ? d[w-1] : s;
                end
            end
            3'd4: if (n > 0) begin
                r   = n % w;
                res = ((d << r) | (d >> (w - r))) & mask;
                cy  = res[0];
            end
            3'd5: if (n > 0) begin
                r   = n % w;
                res = ((d >> r) | (d << (w - r))) & mask;
                cy  = res[w-1];
            end
            3'd6: if (d == mask) begin
                res = sat ? mask : 32'd0;
                cy  = 1'b1;
            end else begin
                res = d + 32'd1;
                cy  = 1'b0;
            end
            3'd7: if (d == 32'd0) begin
                res = sat ? 32'd0 : mask;
                cy  = 1'b1;
            end else begin
                res = d - 32'd1;
                cy  = 1'b0;
            end
            default: begin res = d; cy = c; end
        endcase
        return {cy, res};
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_done);
        for (int k = 0; k < 3; k++) begin
            check({tag, ".data"},  k, od[k], md[k]);
            check({tag, ".carry"}, k, {31'd0, oc[k]}, {31'd0, mc[k]});
            check({tag, ".zero"},  k, {31'd0, oz[k]}, {31'd0, md[k] == 32'd0});
            check({tag, ".busy"},  k, {31'd0, ob[k]}, 32'd0);
            check({tag, ".done"},  k, {31'd0, odn[k]}, {31'd0, exp_done});
            check({tag, ".ready"}, k, {31'd0, ordy[k]}, 32'd1);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            md[k] = 32'd0;
            mc[k] = 1'b0;
        end
    endtask

    // Present one command, hold a bogus LOAD on the bus while busy, then check.
    task automatic do_cmd(input logic [2:0] o, input logic [15:0] din, input logic [4:0] sh, input logic s);
        int cyc;
        op_valid = 1'b1; op_i = o; din_i = din; sh_i = sh; sin_i = s;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++)
            {mc[k], md[k]} = ref_op(mw[k], msat[k], o, md[k], {16'd0, din}, int'(sh), s, mc[k]);
        cyc = (o >= 3'd2 && o <= 3'd5 && sh > 5'd1) ? int'(sh) : 1;
        if (cyc > 1) begin
            op_i  = 3'd1;
            din_i = 16'h5A5A;
            for (int e = 1; e < cyc; e++) begin
                for (int k = 0; k < 3; k++) begin
                    check("run.busy",  k, {31'd0, ob[k]}, 32'd1);
                    check("run.ready", k, {31'd0, ordy[k]}, 32'd0);
                    check("run.done",  k, {31'd0, odn[k]}, 32'd0);
                end
                @(posedge clk); #1;
            end
        end
        op_valid = 1'b0;
        check_all("cmd", 1'b1);
    endtask

    task automatic idle();
        op_valid = 1'b0;
        @(posedge clk); #1;
        check_all("idle", 1'b0);
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1; op_valid = 1'b0; op_i = 3'd0; din_i = 16'd0; sh_i = 5'd0; sin_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst.data",  k, od[k], 32'd0);
            check("rst.zero",  k, {31'd0, oz[k]}, 32'd1);
            check("rst.ready", k, {31'd0, ordy[k]}, 32'd0);
        end
        reset = 1'b0; #1;
        check_all("rst", 1'b0);

        // LOAD then one idle cycle: done is a single pulse
        do_cmd(3'd1, 16'h00A5, 5'd0, 1'b0);
        idle();
        // reset clears contents
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; #1;
        model_reset();
        check_all("rst2", 1'b0);

        // SHL by 3 with fill of ones
        do_cmd(3'd1, 16'h0081, 5'd0, 1'b0);
        do_cmd(3'd2, 16'h0000, 5'd3, 1'b1);
        idle();
        // ROR by full width and by zero
        do_cmd(3'd1, 16'h0001, 5'd0, 1'b0);
        do_cmd(3'd5, 16'h0000, 5'd8, 1'b0);
        do_cmd(3'd5, 16'h0000, 5'd0, 1'b0);
        // INC/DEC at the wrap/saturate boundaries
        do_cmd(3'd1, 16'hFFFF, 5'd0, 1'b0);
        do_cmd(3'd6, 16'h0000, 5'd0, 1'b0);
        do_cmd(3'd7, 16'h0000, 5'd0, 1'b0);
        do_cmd(3'd1, 16'h0000, 5'd0, 1'b0);
        do_cmd(3'd7, 16'h0000, 5'd0, 1'b0);
        do_cmd(3'd0, 16'h1234, 5'd0, 1'b0);
        idle();

        // SHR by 5 aborted by reset on the third step edge
        do_cmd(3'd1, 16'h00F0, 5'd0, 1'b0);
        op_valid = 1'b1; op_i = 3'd3; sh_i = 5'd5; sin_i = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; #1;
        model_reset();
        check_all("abort", 1'b0);
        repeat (3) idle();
        // back-to-back single-cycle commands keep done high
        do_cmd(3'd1, 16'h0010, 5'd0, 1'b0);
        do_cmd(3'd6, 16'h0000, 5'd0, 1'b0);
        do_cmd(3'd6, 16'h0000, 5'd0, 1'b0);
        idle();

        // randomized commands
        for (int i = 0; i < 200; i++) begin
            do_cmd(3'($urandom_range(0, 7)), 16'($urandom), 5'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
